// File: rtl/aes_pkg.sv
// aes_pkg: types and constants shared by the AES round controller, the round
// datapath and the key schedule.
//   ctrl_state_t : sequencer FSM states
//   dp_op_t      : datapath operation select (encoding is visible on dp_op)
package aes_pkg;

  localparam int AES_NB        = 4;   // state columns (32-bit words)
  localparam int AES128_ROUNDS = 10;  // rounds after the initial AddRoundKey

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARK,
    ST_SUB,
    ST_SHIFT,
    ST_MIX,
    ST_DONE
  } ctrl_state_t;

  typedef enum logic [1:0] {
    OP_SUB   = 2'd0,
    OP_SHIFT = 2'd1,
    OP_MIX   = 2'd2,
    OP_ARK   = 2'd3
  } dp_op_t;

endpackage

// File: rtl/aes_stage_timer.sv
// aes_stage_timer: measures how long the current datapath stage is held.
//   clk, rst_n : clock, async active-low reset
//   start_i    : first cycle of a stage (the cycle the stage is enabled)
//   done_o     : last cycle of the stage; the controller advances on this edge
//   busy_o     : stage already started, still waiting out its latency
// A stage lasts STAGE_LAT cycles including the start cycle, so with
// STAGE_LAT=1 done_o fires in the start cycle itself.
module aes_stage_timer #(
  parameter int STAGE_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  output logic done_o,
  output logic busy_o
);

  localparam int CW = $clog2(STAGE_LAT + 1);
  localparam bit SINGLE = (STAGE_LAT == 1);

  // Remaining cycles after the current one; 0 means no stage in flight.
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i)             cnt_d = CW'(STAGE_LAT - 1);
    else if (cnt_q != '0)    cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done_o = start_i ? SINGLE : (cnt_q == CW'(1));
  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 encryption sequencer. Accepts a block via
// in_valid/in_ready, walks the shared round datapath through round 0..NUM_ROUNDS
// (ARK, then SUB/SHIFT/MIX/ARK per round, MIX skipped in the final round),
// fetching each round key, and offers the result via out_valid/out_ready.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : block request handshake
//   dp_load             : datapath captures the input block (accept cycle)
//   dp_en, dp_op        : stage enable and op select (0 SUB,1 SHIFT,2 MIX,3 ARK)
//   key_req, key_round  : round-key request and current round index
//   key_valid           : key schedule presents the key for key_round
//   out_valid/out_ready : ciphertext handshake
//   busy                : controller not idle
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS,
  parameter int STAGE_LAT  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       dp_load,
  output logic       dp_en,
  output logic [1:0] dp_op,
  output logic       key_req,
  output logic [3:0] key_round,
  input  logic       key_valid,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  ctrl_state_t state_q;
  logic [3:0]  round_q;
  logic        in_ready_q, out_valid_q, busy_q;
  logic        tmr_start, tmr_done, tmr_busy;
  dp_op_t      op_sel;
  logic        last_rnd;

  assign last_rnd = (round_q == LAST_RND);

  aes_stage_timer #(.STAGE_LAT(STAGE_LAT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (tmr_start),
    .done_o  (tmr_done),
    .busy_o  (tmr_busy)
  );

  // A stage starts on its first cycle (timer idle); ARK additionally waits for
  // the key, so a missing key keeps the timer from starting.
  always_comb begin
    tmr_start = 1'b0;
    key_req   = 1'b0;
    op_sel    = OP_SUB;
    case (state_q)
      ST_SUB:   begin op_sel = OP_SUB;   tmr_start = !tmr_busy; end
      ST_SHIFT: begin op_sel = OP_SHIFT; tmr_start = !tmr_busy; end
      ST_MIX:   begin op_sel = OP_MIX;   tmr_start = !tmr_busy; end
      ST_ARK: begin
        op_sel    = OP_ARK;
        key_req   = !tmr_busy;
        tmr_start = !tmr_busy && key_valid;
      end
      default: ;
    endcase
  end

  assign dp_en     = tmr_start;
  assign dp_op     = dp_en ? op_sel : OP_SUB;
  assign dp_load   = in_valid && in_ready_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign key_round = round_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      round_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (in_valid) begin
          state_q    <= ST_ARK;
          round_q    <= '0;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
        end
        ST_SUB:   if (tmr_done) state_q <= ST_SHIFT;
        ST_SHIFT: if (tmr_done) state_q <= last_rnd ? ST_ARK : ST_MIX;
        ST_MIX:   if (tmr_done) state_q <= ST_ARK;
        ST_ARK: if (tmr_done) begin
          if (last_rnd) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end else begin
            round_q <= round_q + 4'd1;
            state_q <= ST_SUB;
          end
        end
        ST_DONE: if (out_ready) begin
          state_q     <= ST_IDLE;
          round_q     <= '0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          round_q     <= '0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
module tb_aes_round_ctrl;

  localparam int NR = 10;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, key_valid = 1'b0;
  logic sel = 1'b0;  // 0: STAGE_LAT=1 instance, 1: STAGE_LAT=3 instance

  logic       a_in_ready, a_dp_load, a_dp_en, a_key_req, a_out_valid, a_busy;
  logic [1:0] a_dp_op;
  logic [3:0] a_key_round;
  logic       b_in_ready, b_dp_load, b_dp_en, b_key_req, b_out_valid, b_busy;
  logic [1:0] b_dp_op;
  logic [3:0] b_key_round;

  logic       s_in_ready, s_dp_load, s_dp_en, s_key_req, s_out_valid, s_busy;
  logic [1:0] s_dp_op;
  logic [3:0] s_key_round;

  assign s_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign s_dp_load   = sel ? b_dp_load   : a_dp_load;
  assign s_dp_en     = sel ? b_dp_en     : a_dp_en;
  assign s_dp_op     = sel ? b_dp_op     : a_dp_op;
  assign s_key_req   = sel ? b_key_req   : a_key_req;
  assign s_key_round = sel ? b_key_round : a_key_round;
  assign s_out_valid = sel ? b_out_valid : a_out_valid;
  assign s_busy      = sel ? b_busy      : a_busy;

  aes_round_ctrl #(.NUM_ROUNDS(NR), .STAGE_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .dp_load(a_dp_load), .dp_en(a_dp_en), .dp_op(a_dp_op), .key_req(a_key_req),
    .key_round(a_key_round), .key_valid(key_valid), .out_valid(a_out_valid),
    .out_ready(out_ready), .busy(a_busy));

  aes_round_ctrl #(.NUM_ROUNDS(NR), .STAGE_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .dp_load(b_dp_load), .dp_en(b_dp_en), .dp_op(b_dp_op), .key_req(b_key_req),
    .key_round(b_key_round), .key_valid(key_valid), .out_valid(b_out_valid),
    .out_ready(out_ready), .busy(b_busy));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int delay [0:15];          // key stall cycles per round's ARK
  int exp_op[$], exp_rnd[$], exp_cyc[$];
  int exp_done;

  // Reference: op list per round and the cycle (counted from the accept edge)
  // at which each op's enable must appear, plus the out_valid cycle.
  task automatic build_model(input int lat);
    int t;
    exp_op.delete(); exp_rnd.delete(); exp_cyc.delete();
    t = 1;
    for (int r = 0; r <= NR; r++) begin
      int ops[$];
      ops.delete();
      if (r > 0) begin
        ops.push_back(0); ops.push_back(1);
        if (r < NR) ops.push_back(2);
      end
      ops.push_back(3);
      foreach (ops[k]) begin
        if (ops[k] == 3) t += delay[r];
        exp_op.push_back(ops[k]); exp_rnd.push_back(r); exp_cyc.push_back(t);
        t += lat;
      end
    end
    exp_done = t;
  endtask

  task automatic clear_delays();
    for (int i = 0; i < 16; i++) delay[i] = 0;
  endtask

  task automatic do_reset();
    in_valid = 0; out_ready = 0; key_valid = 0;
    @(negedge clk); rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // One block: accept, step through all ops with a key responder honouring
  // delay[], then hold DONE for rdy_wait cycles. abort_rnd>=0 asserts reset
  // during that round's SHIFT and returns with rst_n low.
  task automatic run_block(input int lat, input bit keep, input int rdy_wait,
                           input int abort_rnd);
    int c, ev, cur_ark, wcnt;
    build_model(lat);
    @(negedge clk);
    in_valid = 1; out_ready = 1'($urandom); key_valid = 1'($urandom);
    #1;
    n_chk++;
    if (s_in_ready !== 1'b1 || s_dp_load !== 1'b1 || s_dp_en !== 1'b0 || s_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL accept: in_ready=%b dp_load=%b dp_en=%b busy=%b, want 1 1 0 0",
               s_in_ready, s_dp_load, s_dp_en, s_busy);
    end
    c = 0; ev = 0; cur_ark = 0; wcnt = 0;
    forever begin
      @(negedge clk); c++;
      if (s_out_valid === 1'b1) break;
      if (c > 2000) begin
        n_chk++; n_fail++;
        $display("FAIL timeout: no out_valid after %0d cycles, want %0d", c, exp_done);
        return;
      end
      in_valid  = keep ? 1'b1 : 1'($urandom);
      out_ready = 1'($urandom);
      if (s_key_req === 1'b1) begin
        if (wcnt < delay[cur_ark]) begin key_valid = 0; wcnt++; end
        else key_valid = 1;
      end else key_valid = 1'($urandom);
      #1;
      if (s_key_req === 1'b1 && !key_valid) begin
        n_chk++;
        if (s_dp_en !== 1'b0 || s_key_round !== cur_ark) begin
          n_fail++;
          $display("FAIL stall c=%0d: dp_en=%b key_round=%0d, want 0 %0d",
                   c, s_dp_en, s_key_round, cur_ark);
        end
      end
      n_chk++;
      if (s_busy !== 1'b1 || s_in_ready !== 1'b0 || s_dp_load !== 1'b0 ||
          (s_dp_en !== 1'b1 && s_dp_op !== 2'd0)) begin
        n_fail++;
        $display("FAIL busy_ctl c=%0d: busy=%b in_ready=%b dp_load=%b dp_en=%b dp_op=%0d, want 1 0 0 x (op 0 if !en)",
                 c, s_busy, s_in_ready, s_dp_load, s_dp_en, s_dp_op);
      end
      if (s_dp_en === 1'b1) begin
        n_chk++;
        if (ev >= exp_op.size()) begin
          n_fail++;
          $display("FAIL step: extra enable c=%0d op=%0d", c, s_dp_op);
        end else if (s_dp_op !== exp_op[ev] || s_key_round !== exp_rnd[ev] || c != exp_cyc[ev]) begin
          n_fail++;
          $display("FAIL step %0d: op=%0d rnd=%0d cyc=%0d, want op=%0d rnd=%0d cyc=%0d",
                   ev, s_dp_op, s_key_round, c, exp_op[ev], exp_rnd[ev], exp_cyc[ev]);
        end
        if (s_dp_op == 2'd3) begin cur_ark++; wcnt = 0; end
        if (abort_rnd >= 0 && s_dp_op == 2'd1 && s_key_round == abort_rnd) begin
          in_valid = 0;
          rst_n = 0;
          #1;
          n_chk++;
          if (s_in_ready !== 1'b1 || s_busy !== 1'b0 || s_dp_en !== 1'b0 || s_dp_load !== 1'b0 ||
              s_key_req !== 1'b0 || s_key_round !== 4'd0 || s_out_valid !== 1'b0 || s_dp_op !== 2'd0) begin
            n_fail++;
            $display("FAIL abort: in_ready=%b busy=%b dp_en=%b dp_load=%b key_req=%b rnd=%0d out_valid=%b op=%0d, want 1 0 0 0 0 0 0 0",
                     s_in_ready, s_busy, s_dp_en, s_dp_load, s_key_req, s_key_round, s_out_valid, s_dp_op);
          end
          return;
        end
        ev++;
      end
    end
    n_chk++;
    if (c != exp_done || ev != exp_op.size()) begin
      n_fail++;
      $display("FAIL latency: out_valid at %0d after %0d ops, want %0d after %0d ops",
               c, ev, exp_done, exp_op.size());
    end
    for (int w = 0; w <= rdy_wait; w++) begin
      if (w > 0) @(negedge clk);
      out_ready = (w == rdy_wait);
      in_valid  = 1'b1;
      key_valid = 1'($urandom);
      #1;
      n_chk++;
      if (s_out_valid !== 1'b1 || s_in_ready !== 1'b0 || s_dp_load !== 1'b0 ||
          s_dp_en !== 1'b0 || s_busy !== 1'b1 || s_key_req !== 1'b0) begin
        n_fail++;
        $display("FAIL done_hold w=%0d: out_valid=%b in_ready=%b dp_load=%b dp_en=%b busy=%b key_req=%b, want 1 0 0 0 1 0",
                 w, s_out_valid, s_in_ready, s_dp_load, s_dp_en, s_busy, s_key_req);
      end
    end
    if (!keep) begin
      @(negedge clk);
      in_valid = 0; out_ready = 1'($urandom);
      #1;
      n_chk++;
      if (s_in_ready !== 1'b1 || s_busy !== 1'b0 || s_out_valid !== 1'b0 ||
          s_dp_en !== 1'b0 || s_dp_load !== 1'b0 || s_key_round !== 4'd0) begin
        n_fail++;
        $display("FAIL idle_after: in_ready=%b busy=%b out_valid=%b dp_en=%b dp_load=%b rnd=%0d, want 1 0 0 0 0 0",
                 s_in_ready, s_busy, s_out_valid, s_dp_en, s_dp_load, s_key_round);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 0; out_ready = 0; key_valid = 0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (a_in_ready !== 1'b1 || a_dp_load !== 1'b0 || a_dp_en !== 1'b0 || a_dp_op !== 2'd0 ||
        a_key_req !== 1'b0 || a_key_round !== 4'd0 || a_out_valid !== 1'b0 || a_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_lat1: ir=%b ld=%b en=%b op=%0d kr=%b rnd=%0d ov=%b busy=%b, want 1 0 0 0 0 0 0 0",
               a_in_ready, a_dp_load, a_dp_en, a_dp_op, a_key_req, a_key_round, a_out_valid, a_busy);
    end
    n_chk++;
    if (b_in_ready !== 1'b1 || b_dp_load !== 1'b0 || b_dp_en !== 1'b0 || b_dp_op !== 2'd0 ||
        b_key_req !== 1'b0 || b_key_round !== 4'd0 || b_out_valid !== 1'b0 || b_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_lat3: ir=%b ld=%b en=%b op=%0d kr=%b rnd=%0d ov=%b busy=%b, want 1 0 0 0 0 0 0 0",
               b_in_ready, b_dp_load, b_dp_en, b_dp_op, b_key_req, b_key_round, b_out_valid, b_busy);
    end
    rst_n = 1;
  endtask

  task automatic test_single_block();
    do_reset(); clear_delays(); sel = 0;
    run_block(1, 0, 0, -1);
  endtask

  task automatic test_key_stall();
    do_reset(); clear_delays(); sel = 0;
    delay[3] = 5;
    run_block(1, 0, 0, -1);
  endtask

  task automatic test_out_hold();
    do_reset(); clear_delays(); sel = 0;
    run_block(1, 0, 7, -1);
  endtask

  task automatic test_reset_mid();
    do_reset(); clear_delays(); sel = 0;
    run_block(1, 0, 0, 6);
    repeat (2) begin
      @(negedge clk); #1;
      n_chk++;
      if (s_out_valid !== 1'b0 || s_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: out_valid=%b busy=%b, want 0 0", s_out_valid, s_busy);
      end
    end
    rst_n = 1;
    run_block(1, 0, 0, -1);
  endtask

  task automatic test_stage_lat3();
    do_reset(); clear_delays(); sel = 1;
    run_block(3, 0, 0, -1);
    delay[0] = 2; delay[NR] = 4;
    run_block(3, 0, 2, -1);
    sel = 0;
  endtask

  task automatic test_back_to_back();
    do_reset(); clear_delays(); sel = 0;
    repeat (3) run_block(1, 1, 0, -1);
  endtask

  task automatic test_random();
    for (int b = 0; b < 6; b++) begin
      do_reset();
      for (int r = 0; r <= NR; r++) delay[r] = $urandom_range(0, 3);
      sel = (b % 3 == 2);
      run_block(sel ? 3 : 1, 1'($urandom), $urandom_range(0, 3), -1);
    end
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_key_stall();
    test_out_hold();
    test_reset_mid();
    test_stage_lat3();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
